// File: rtl/gf2_cyclic_reducer.sv
// Folds a 2N-bit GF(2) product modulo x^N - 1 and streams the N-bit result
// as NW words of WW bits, lowest degree first, with ready/valid backpressure.
module gf2_cyclic_reducer #(
    parameter int N  = 17669,
    parameter int WW = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2*N-1:0]  prod_in,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WW-1:0]   out_data,
    output logic [15:0]     out_idx,
    output logic            out_last,
    output logic            done
);

    localparam int NW = (N + WW - 1) / WW;
    localparam int PW = NW * WW;
    localparam logic [15:0] LAST_IDX = 16'(NW - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t state, state_next;

    // Halves are zero-padded to a whole number of words, so bits at or above
    // N in the last word read 0 and shifting needs no extra masking.
    logic [PW-1:0] lo;
    logic [PW-1:0] hi;

    logic capture;
    logic xfer;

    assign capture   = (state == IDLE) && start;
    assign out_valid = (state == STREAM);
    assign xfer      = out_valid && out_ready;
    assign out_last  = out_valid && (out_idx == LAST_IDX);
    assign out_data  = out_valid ? (lo[WW-1:0] ^ hi[WW-1:0]) : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (xfer && out_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            out_idx <= '0;
        end else begin
            state <= state_next;
            if (capture)
                out_idx <= '0;
            else if (xfer && !out_last)
                out_idx <= out_idx + 16'd1;
        end
    end

    // Data path carries no reset; outputs are gated by the state instead.
    always_ff @(posedge clk) begin
        if (capture) begin
            lo <= PW'(prod_in[N-1:0]);
            hi <= PW'(prod_in[2*N-1:N]);
        end else if (xfer) begin
            lo <= lo >> WW;
            hi <= hi >> WW;
        end
    end

endmodule

// File: tb/tb_gf2_cyclic_reducer.sv
// Directed bench for gf2_cyclic_reducer at default sizing (N=17669, WW=64),
// checking every streamed word against reference reductions built here.
module tb_gf2_cyclic_reducer;

    localparam int N  = 17669;
    localparam int WW = 64;
    localparam int NW = (N + WW - 1) / WW;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2*N-1:0]  prod_in;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [WW-1:0]   out_data;
    logic [15:0]     out_idx;
    logic            out_last;
    logic            done;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]    exp_r;
    logic [127:0]    u_op;
    logic [127:0]    v_op;
    int              seen_done;

    gf2_cyclic_reducer #(.N(N), .WW(WW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prod_in   (prod_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [N-1:0] reduce_model(input logic [2*N-1:0] p);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = p[i] ^ p[i+N];
        return r;
    endfunction

    // Starts an operation on the current prod_in and checks every word;
    // optional stall at one index and an ignored start pulse at another.
    task automatic run_stream(input logic [N-1:0] expv, input int stall_at,
                              input int stall_len, input int pulse_at, input string tag);
        logic [NW*WW-1:0] exp_w;
        int idx;
        int cyc;
        int stalled;
        exp_w = '0;
        exp_w[N-1:0] = expv;
        idx = 0;
        cyc = 0;
        stalled = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (idx < NW && cyc < 4*NW) begin
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            if (out_valid !== 1'b1) break;
            chk({tag, "_idx"}, 64'(out_idx), 64'(idx));
            chk({tag, "_data"}, out_data, exp_w[idx*WW +: WW]);
            chk({tag, "_last"}, 64'(out_last), 64'(idx == NW-1));
            chk({tag, "_done_low"}, 64'(done), 64'd0);
            start = (idx == pulse_at);
            if (start) prod_in = ~prod_in;
            if (idx == stall_at && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk({tag, "_xfers"}, 64'(idx), 64'(NW));
        chk({tag, "_cycles"}, 64'(cyc), 64'(NW + stall_len));
        chk({tag, "_done_pulse"}, 64'(done), 64'd1);
        chk({tag, "_valid_in_done"}, 64'(out_valid), 64'd0);
        chk({tag, "_data_in_done"}, out_data, 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_once"}, 64'(done), 64'd0);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
        chk({tag, "_valid_idle"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        prod_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_idx", 64'(out_idx), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        // Reset wins over a start in the same cycle.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_over_start", 64'(busy), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // x^0 passes straight through.
        prod_in = '0;
        prod_in[0] = 1'b1;
        exp_r = '0;
        exp_r[0] = 1'b1;
        run_stream(exp_r, -1, 0, -1, "one");

        // x^N wraps to x^0.
        prod_in = '0;
        prod_in[N] = 1'b1;
        run_stream(exp_r, -1, 0, -1, "wrap");

        // x^(N-1) + x^(2N-1) cancels.
        prod_in = '0;
        prod_in[N-1] = 1'b1;
        prod_in[2*N-1] = 1'b1;
        exp_r = '0;
        run_stream(exp_r, -1, 0, -1, "cancel");

        // x^(N-1) alone lands as 0x10 in word 276.
        prod_in = '0;
        prod_in[N-1] = 1'b1;
        exp_r = '0;
        exp_r[N-1] = 1'b1;
        run_stream(exp_r, -1, 0, -1, "top");

        // Top input bit folds into r[N-1]; mixed low/high bits.
        prod_in = '0;
        prod_in[2*N-1] = 1'b1;
        prod_in[3] = 1'b1;
        prod_in[N+70] = 1'b1;
        prod_in[N+200] = 1'b1;
        prod_in[200] = 1'b1;
        exp_r = '0;
        exp_r[N-1] = 1'b1;
        exp_r[3] = 1'b1;
        exp_r[70] = 1'b1;
        run_stream(exp_r, -1, 0, -1, "fold");

        // Backpressure: 3 stalled cycles at word 5.
        for (int k = 0; k < 2*N; k++) prod_in[k] = 1'($urandom_range(0, 1));
        exp_r = reduce_model(prod_in);
        run_stream(exp_r, 5, 3, -1, "stall");

        // Start pulse mid-stream with changed prod_in must be ignored.
        for (int k = 0; k < 2*N; k++) prod_in[k] = 1'($urandom_range(0, 1));
        exp_r = reduce_model(prod_in);
        run_stream(exp_r, -1, 0, 10, "restart_ign");

        // Reset at word 100 aborts without a done pulse.
        for (int k = 0; k < 2*N; k++) prod_in[k] = 1'($urandom_range(0, 1));
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_at_idx", 64'(out_idx), 64'd100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_idx", 64'(out_idx), 64'd0);
        chk("abort_data", out_data, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        seen_done = 0;
        for (int c = 0; c < NW + 5; c++) begin
            if (done === 1'b1) seen_done++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        for (int k = 0; k < 2*N; k++) prod_in[k] = 1'($urandom_range(0, 1));
        exp_r = reduce_model(prod_in);
        run_stream(exp_r, -1, 0, -1, "after_abort");

        // End to end: carry-less product of U and V, schoolbook reduced.
        u_op = 128'd4892378128957813477589134;
        v_op = 128'd2398457699321345184592348;
        prod_in = '0;
        exp_r = '0;
        for (int i = 0; i < 128; i++) begin
            for (int j = 0; j < 128; j++) begin
                if (u_op[i] && v_op[j]) begin
                    prod_in[i+j] = ~prod_in[i+j];
                    exp_r[(i+j) % N] = ~exp_r[(i+j) % N];
                end
            end
        end
        run_stream(exp_r, -1, 0, -1, "e2e");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
